// File: rtl/key_schedule_engine.sv
// AES key expansion: streams the Nr+1 round keys of an AES-128/192/256 key, one 32-bit word per cycle.
// Latency: round r is valid 5+4r cycles after the start cycle when the consumer never stalls.
// Backpressure: rk_valid/rk_ready handshake; when the output register is held, word generation stalls.

// Forward AES S-box: multiplicative inverse in GF(2^8), then the affine map.
module forward_substitution_box (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  logic [7:0] sq [8];
  logic [7:0] inv;

  // inverse = din^254 = product of din^(2^k) for k=1..7; zero maps to zero
  always_comb begin
    sq[0] = din;
    for (int k = 1; k < 8; k++) sq[k] = gf_mul(sq[k-1], sq[k-1]);
    inv = sq[1];
    for (int k = 2; k < 8; k++) inv = gf_mul(inv, sq[k]);
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module key_schedule_engine #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] inp_key,
  input  logic         abort,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int WIW = (MAX_NK > 4) ? 3 : 2;

  typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [31:0] kw  [8];
  logic [31:0] win [MAX_NK];   // win[0] = w[i-1], win[Nk-1] = w[i-Nk]
  logic [31:0] acc [3];        // first three words of the round being built

  logic [2:0]  nk_m1;
  logic [5:0]  last_i;
  logic [5:0]  widx;           // i
  logic [2:0]  wmod;           // i mod Nk
  logic [3:0]  wdiv;           // i / Nk

  logic [2:0]  req_nk_m1;
  logic [5:0]  req_last;
  logic        req_legal;
  logic        accept, reject, gen_en, fin, out_free, out_load;
  logic [31:0] prev, oldest, rot, sub_in, sub_out, tmix, word;
  logic [7:0]  rcon;

  for (genvar j = 0; j < 8; j++) begin : g_kw
    assign kw[j] = inp_key[255-32*j -: 32];
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    forward_substitution_box u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  assign busy     = (state != IDLE);
  assign out_free = !rk_valid || rk_ready;
  // the fourth word of a round goes straight to the output register, so only it can stall
  assign gen_en   = (state == GEN) && !abort && ((widx[1:0] != 2'd3) || out_free);
  assign out_load = gen_en && (widx[1:0] == 2'd3);
  assign fin      = (state == DRAIN) && !abort && rk_valid && rk_ready;

  // decode the requested key length and check it against the window depth
  always_comb begin
    req_nk_m1 = 3'd3;
    req_last  = 6'd43;
    req_legal = 1'b0;
    case (key_len)
      2'b00: begin req_nk_m1 = 3'd3; req_last = 6'd43; req_legal = (MAX_NK >= 4); end
      2'b01: begin req_nk_m1 = 3'd5; req_last = 6'd51; req_legal = (MAX_NK >= 6); end
      2'b10: begin req_nk_m1 = 3'd7; req_last = 6'd59; req_legal = (MAX_NK >= 8); end
      default: req_legal = 1'b0;
    endcase
  end

  // Rcon byte for i/Nk
  always_comb begin
    rcon = 8'h00;
    case (wdiv)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // next word: key words rotate out of the window first, then w[i-Nk] ^ t
  always_comb begin
    prev   = win[0];
    oldest = win[nk_m1[WIW-1:0]];
    rot    = {prev[23:0], prev[31:24]};
    sub_in = (wmod == 3'd0) ? rot : prev;
    tmix   = prev;
    if (wdiv == 4'd0)                         tmix = 32'h0;
    else if (wmod == 3'd0)                    tmix = sub_out ^ {rcon, 24'h0};
    else if (nk_m1 == 3'd7 && wmod == 3'd4)   tmix = sub_out;
    word = oldest ^ tmix;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: abort beats start and any progress
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (req_legal) begin
            accept    = 1'b1;
            state_nxt = GEN;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      GEN: begin
        if (abort)                          state_nxt = IDLE;
        else if (gen_en && widx == last_i)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort || fin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // counters, window, accumulator and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      nk_m1    <= 3'd0;
      last_i   <= 6'd0;
      widx     <= 6'd0;
      wmod     <= 3'd0;
      wdiv     <= 4'd0;
      for (int k = 0; k < MAX_NK; k++) win[k] <= 32'h0;
      for (int k = 0; k < 3; k++) acc[k] <= 32'h0;
      rk_valid <= 1'b0;
      rk_data  <= 128'h0;
      rk_round <= 4'd0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= fin;
      err  <= reject;
      if (accept) begin
        nk_m1  <= req_nk_m1;
        last_i <= req_last;
        widx   <= 6'd0;
        wmod   <= 3'd0;
        wdiv   <= 4'd0;
        // key word j lands at win[Nk-1-j] so the oldest slot yields words in order
        for (int k = 0; k < MAX_NK; k++) begin
          if (3'(k) <= req_nk_m1) win[k] <= kw[req_nk_m1 - 3'(k)];
          else                    win[k] <= 32'h0;
        end
        for (int k = 0; k < 3; k++) acc[k] <= 32'h0;
      end else if (gen_en) begin
        win[0] <= word;
        for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
        if (widx[1:0] != 2'd3) acc[widx[1:0]] <= word;
        widx <= widx + 6'd1;
        if (wmod == nk_m1) begin
          wmod <= 3'd0;
          wdiv <= wdiv + 4'd1;
        end else begin
          wmod <= wmod + 3'd1;
        end
      end
      if (abort && state != IDLE) begin
        rk_valid <= 1'b0;
        rk_data  <= 128'h0;
        rk_round <= 4'd0;
      end else if (out_load) begin
        rk_valid <= 1'b1;
        rk_data  <= {acc[0], acc[1], acc[2], word};
        rk_round <= widx[5:2];
      end else if (rk_valid && rk_ready) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_engine.sv
module tb_key_schedule_engine;

  logic         clk = 1'b0;
  logic         rst, start, start4, abort, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] inp_key;
  logic         rk_valid, busy, done, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_valid4, busy4, done4, err4;
  logic [127:0] rk_data4;
  logic [3:0]   rk_round4;

  key_schedule_engine #(.MAX_NK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .inp_key(inp_key),
    .abort(abort), .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_data(rk_data),
    .rk_round(rk_round), .busy(busy), .done(done), .err(err));

  key_schedule_engine #(.MAX_NK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .key_len(key_len), .inp_key(inp_key),
    .abort(abort), .rk_ready(rk_ready), .rk_valid(rk_valid4), .rk_data(rk_data4),
    .rk_round(rk_round4), .busy(busy4), .done(done4), .err(err4));

  always #5 clk = ~clk;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'hdeadbeefcafef00d0123456789abcdef};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                   64'hffff0000ffff0000};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbt [256];
  logic [31:0] mw  [60];
  int          m_nr;

  // polynomial product reduced by long division modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h11b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    if (b != 8'h00)
      for (int x = 1; x < 256; x++) if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_m(input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int j = 1; j < n; j++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  task automatic build_model(input logic [255:0] key, input logic [1:0] kl);
    int nk;
    logic [31:0] t;
    nk   = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
    m_nr = nk + 6;
    for (int i = 0; i < 4 * (m_nr + 1); i++) begin
      if (i < nk) begin
        mw[i] = key[255-32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0)               t = subw({t[23:0], t[31:24]}) ^ {rcon_m(i / nk), 24'h0};
        else if (nk > 6 && i % nk == 4) t = subw(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // ---------------- compare process ----------------
  bit          chk_en = 0, lat_chk = 0, rnd_mode = 0, done_due = 0, stalled = 0;
  int          exp_idx = 0, t0 = 0, done_cnt = 0;
  logic [127:0] held_d;
  logic [3:0]   held_r;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("done_pulse", done, done_due);
      if (done) done_cnt++;
      done_due = 0;
      chk("err_quiet", err, 0);
      if (rk_valid) begin
        if (exp_idx > m_nr) begin
          checks++;
          errors++;
          $display("FAIL extra_round actual=%0d required<=%0d", rk_round, m_nr);
        end else begin
          chk("rk_round", rk_round, exp_idx);
          chk("rk_data", rk_data, model_rk(exp_idx));
          if (stalled) begin
            chk("stable_data", rk_data, held_d);
            chk("stable_round", rk_round, held_r);
          end else if (lat_chk) begin
            chk("latency", cyc, t0 + 5 + 4 * exp_idx);
          end
          if (rk_ready) begin
            if (exp_idx == m_nr) done_due = 1;
            exp_idx++;
            stalled = 0;
          end else begin
            stalled = 1;
            held_d  = rk_data;
            held_r  = rk_round;
          end
        end
      end else begin
        if (stalled) chk("valid_hold", rk_valid, 1);
        stalled = 0;
      end
    end
  end

  // random consumer back-pressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_mode) rk_ready = ($urandom_range(0, 99) < 40);
  end

  // full expansion; poke>=0 re-asserts start (with a reserved length) while busy
  task automatic run(input logic [255:0] key, input logic [1:0] kl, input bit rnd, input int poke);
    build_model(key, kl);
    exp_idx  = 0;
    stalled  = 0;
    done_due = 0;
    done_cnt = 0;
    lat_chk  = !rnd;
    if (!rnd) rk_ready = 1'b1;
    rnd_mode = rnd;
    inp_key  = key;
    key_len  = kl;
    start    = 1'b1;
    t0       = cyc;
    chk_en   = 1;
    tick();
    start = 1'b0;
    chk("busy_on", busy, 1);
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      if (n == poke) begin
        start   = 1'b1;
        key_len = 2'b11;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=done");
    end
    chk("rounds_seen", exp_idx, m_nr + 1);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk_en   = 0;
    rnd_mode = 0;
    rk_ready = 1'b1;
  endtask

  // AES-128 expansion interrupted by abort or reset while round 5 is presented
  task automatic interrupt(input bit use_rst);
    bool_found: begin end
    build_model(K128, 2'b00);
    exp_idx  = 0;
    stalled  = 0;
    done_due = 0;
    lat_chk  = 1;
    rk_ready = 1'b1;
    inp_key  = K128;
    key_len  = 2'b00;
    start    = 1'b1;
    t0       = cyc;
    chk_en   = 1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 200 && !(rk_valid && rk_round == 4'd5); n++) tick();
    chk("reach_round5", rk_valid && rk_round == 4'd5, 1);
    chk_en = 0;
    if (use_rst) rst = 1'b1;
    else         abort = 1'b1;
    tick();
    rst   = 1'b0;
    abort = 1'b0;
    chk("cut_rk_valid", rk_valid, 0);
    chk("cut_rk_data", rk_data, 0);
    chk("cut_rk_round", rk_round, 0);
    chk("cut_busy", busy, 0);
    chk("cut_done", done, 0);
    chk("cut_err", err, 0);
    tick();
    chk("cut_no_late_done", done, 0);
    chk("cut_still_idle", busy, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    start4   = 1'b0;
    abort    = 1'b0;
    rk_ready = 1'b1;
    key_len  = 2'b00;
    inp_key  = K128;

    for (int b = 0; b < 256; b++) sbt[b] = sbox_calc(8'(b));
    chk("model_sbox_00", sbt[0], 8'h63);
    chk("model_sbox_53", sbt[8'h53], 8'hed);
    build_model(K128, 2'b00);
    chk("model_128_r1", model_rk(1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_128_r10", model_rk(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    build_model(K192, 2'b01);
    chk("model_192_r12", model_rk(12), 128'ha4970a331a78dc09c418c271e3a41d5d);
    build_model(K256, 2'b10);
    chk("model_256_r14", model_rk(14), 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // reset wins over a simultaneous start
    tick();
    tick();
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_data", rk_data, 0);
    chk("rst_rk_round", rk_round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

    run(K128, 2'b00, 0, -1);
    run(K192, 2'b01, 0, 10);
    run(K256, 2'b10, 0, -1);
    run(K128, 2'b00, 1, -1);

    // reserved key length
    key_len = 2'b11;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("err_reserved", err, 1);
    chk("err_reserved_busy", busy, 0);
    tick();
    chk("err_one_cycle", err, 0);
    chk("err_still_idle", busy, 0);

    // AES-256 on a 4-word window is rejected, AES-128 is accepted
    key_len = 2'b10;
    start4  = 1'b1;
    tick();
    start4 = 1'b0;
    chk("err_nk_too_big", err4, 1);
    chk("err_nk_busy", busy4, 0);
    tick();
    chk("err_nk_one_cycle", err4, 0);
    key_len = 2'b00;
    start4  = 1'b1;
    tick();
    start4 = 1'b0;
    chk("small_accept_busy", busy4, 1);
    chk("small_accept_err", err4, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("small_abort_busy", busy4, 0);
    chk("idle_abort_no_effect", busy, 0);

    // start and abort together in IDLE: abort wins
    key_len = 2'b00;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_err", err, 0);
    tick();
    chk("start_abort_valid", rk_valid, 0);

    interrupt(0);
    run(K256, 2'b10, 0, -1);
    interrupt(1);
    run(K128, 2'b00, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
